// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding and default width.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, combinational, no handshake.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a - b - bin, LSB first; done pulses WIDTH+1 edges after start.
// One operation at a time: start is ignored unless idle, so throughput is one result per WIDTH+2 cycles.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             br_q, bout_q;
  logic             cell_diff, cell_bout;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            br_q   <= bin;
            cnt_q  <= CW'(WIDTH - 1);
            diff_q <= '0;
            bout_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= cell_bout;
          diff_q <= {cell_diff, diff_q[WIDTH-1:1]};
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) bout_q <= cell_bout;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8) and its full_subtractor cell.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic fs_a, fs_b, fs_bin, fs_diff, fs_bout;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  full_subtractor u_fs (
    .a    (fs_a),
    .b    (fs_b),
    .bin  (fs_bin),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and follow it to done; checks latency, busy length, result, pulse width.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] exp_d, input logic exp_b);
    int n;
    int nbusy;
    a = av; b = bv; bin = bi; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    nbusy = 0;
    while (!done && n < 30) begin
      if (busy) nbusy++;
      step();
      n++;
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_busy_cycles"}, nbusy, 8);
    check({tag, "_busy_with_done"}, {31'd0, busy}, 0);
    check({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_d});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_b});
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
    check({tag, "_diff_hold"}, {24'd0, diff}, {24'd0, exp_d});
  endtask

  logic [7:0] bb_a [4];
  logic [7:0] bb_b [4];
  logic       bb_bin [4];
  logic [7:0] bb_d [3];
  logic       bb_bo [3];

  initial begin
    int n, k, last, ndone;
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h11; bin = 1'b0;
    fs_a = 1'b0; fs_b = 1'b0; fs_bin = 1'b0;

    // Full-subtractor cell against integer arithmetic.
    for (int i = 0; i < 8; i++) begin
      int r;
      fs_a = i[2]; fs_b = i[1]; fs_bin = i[0];
      #1;
      r = int'(i[2]) - int'(i[1]) - int'(i[0]);
      check($sformatf("fs_diff_%0d", i), {31'd0, fs_diff}, {31'd0, r[0]});
      check($sformatf("fs_bout_%0d", i), {31'd0, fs_bout}, (r < 0) ? 1 : 0);
    end

    // Reset held with start high: rst must win.
    step();
    step();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_diff", {24'd0, diff}, 0);
    check("rst_bout", {31'd0, bout}, 0);
    rst = 1'b0; start = 1'b0;
    step();
    check("idle_busy", {31'd0, busy}, 0);

    do_op("basic",  8'd100, 8'd37, 1'b0, 8'h3F, 1'b0);
    do_op("wrap",   8'h00,  8'h01, 1'b0, 8'hFF, 1'b1);
    do_op("eq_bin", 8'h55,  8'h55, 1'b1, 8'hFF, 1'b1);
    do_op("msb",    8'h80,  8'h7F, 1'b1, 8'h00, 1'b0);

    // start re-pulsed mid-SHIFT must be ignored entirely.
    a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    n = 4;
    while (!done && n < 30) begin step(); n++; end
    check("repulse_latency", n, 9);
    check("repulse_diff", {24'd0, diff}, 32'h3F);
    check("repulse_bout", {31'd0, bout}, 0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) ndone++;
    end
    check("repulse_no_second_done", ndone, 0);

    // Reset during the 4th SHIFT cycle aborts the operation.
    a = 8'hF0; b = 8'h0F; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("midrst_busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_diff", {24'd0, diff}, 0);
    check("midrst_bout", {31'd0, bout}, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    do_op("after_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

    // Back-to-back with start held high; next operands presented during each done cycle.
    bb_a[0] = 8'd100; bb_b[0] = 8'd37; bb_bin[0] = 1'b0; bb_d[0] = 8'h3F; bb_bo[0] = 1'b0;
    bb_a[1] = 8'h00;  bb_b[1] = 8'h01; bb_bin[1] = 1'b0; bb_d[1] = 8'hFF; bb_bo[1] = 1'b1;
    bb_a[2] = 8'h80;  bb_b[2] = 8'h7F; bb_bin[2] = 1'b1; bb_d[2] = 8'h00; bb_bo[2] = 1'b0;
    bb_a[3] = 8'h00;  bb_b[3] = 8'h00; bb_bin[3] = 1'b0;
    a = bb_a[0]; b = bb_b[0]; bin = bb_bin[0]; start = 1'b1;
    k = 0;
    last = 0;
    for (int cyc = 1; cyc <= 40 && k < 3; cyc++) begin
      step();
      if (done) begin
        check($sformatf("b2b_diff_%0d", k), {24'd0, diff}, {24'd0, bb_d[k]});
        check($sformatf("b2b_bout_%0d", k), {31'd0, bout}, {31'd0, bb_bo[k]});
        check($sformatf("b2b_spacing_%0d", k), cyc - last, (k == 0) ? 9 : 10);
        last = cyc;
        k++;
        a = bb_a[k]; b = bb_b[k]; bin = bb_bin[k];
        if (k == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", k, 3);
    step();
    check("b2b_last_pulse", {31'd0, done}, 0);
    check("b2b_no_extra_op", {31'd0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
